// File: rtl/hazard_fwd_if.sv
// Decode-side hazard/forwarding bundle: operands and bypass sources in,
// forwarded operands and pipeline control out.
interface hazard_fwd_if #(
  parameter int XLEN    = 32,
  parameter int RADDR   = 5,
  parameter int NUM_FWD = 3
);
  logic                     id_valid;
  logic [RADDR-1:0]         id_rs1;
  logic [RADDR-1:0]         id_rs2;
  logic                     id_rs1_use;
  logic                     id_rs2_use;
  logic [XLEN-1:0]          id_a;
  logic [XLEN-1:0]          id_b;
  logic [RADDR-1:0]         ex_rd;
  logic                     ex_we;
  logic                     ex_ld;
  logic [NUM_FWD*RADDR-1:0] stg_rd;
  logic [NUM_FWD-1:0]       stg_we;
  logic [NUM_FWD*XLEN-1:0]  stg_data;
  logic                     br_taken;
  logic [XLEN-1:0]          fwd_a;
  logic [XLEN-1:0]          fwd_b;
  logic                     stall;
  logic                     flush_if_id;
  logic [31:0]              stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_a, id_b,
           ex_rd, ex_we, ex_ld, stg_rd, stg_we, stg_data, br_taken,
    input  fwd_a, fwd_b, stall, flush_if_id, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_a, id_b,
           ex_rd, ex_we, ex_ld, stg_rd, stg_we, stg_data, br_taken,
    output fwd_a, fwd_b, stall, flush_if_id, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// N-source priority bypass plus load-use stall / taken-branch flush sequencing
// and a saturating stall-cycle counter for the 5-stage core.
module hazard_fwd_unit #(
  parameter int XLEN      = 32,
  parameter int RADDR     = 5,
  parameter int NUM_FWD   = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2,
  parameter int EN_FWD    = 1
) (
  input logic        clk1,
  input logic        rst,
  hazard_fwd_if.slave hz
);

  localparam int CTR_MAX = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
  localparam int CTR_W   = (CTR_MAX > 2) ? $clog2(CTR_MAX) : 1;
  localparam logic [CTR_W-1:0] LD_INIT = CTR_W'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  localparam logic [CTR_W-1:0] FL_INIT = CTR_W'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  state_t           state, state_n;
  logic [CTR_W-1:0] ctr, ctr_n;
  logic             stall_c, flush_c;
  logic [31:0]      stall_cnt_q;

  logic [RADDR-1:0] rs1, rs2;
  logic [XLEN-1:0]  byp_a, byp_b;
  logic             hit_a, hit_b;
  logic             ldhz, raw;

  assign rs1 = hz.id_rs1;
  assign rs2 = hz.id_rs2;

  // Walk oldest to youngest so the lowest matching index wins the last write.
  always_comb begin
    byp_a = hz.id_a;
    byp_b = hz.id_b;
    hit_a = hz.ex_we && (hz.ex_rd == rs1);
    hit_b = hz.ex_we && (hz.ex_rd == rs2);
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hz.stg_we[i] && (hz.stg_rd[i*RADDR +: RADDR] == rs1)) begin
        byp_a = hz.stg_data[i*XLEN +: XLEN];
        hit_a = 1'b1;
      end
      if (hz.stg_we[i] && (hz.stg_rd[i*RADDR +: RADDR] == rs2)) begin
        byp_b = hz.stg_data[i*XLEN +: XLEN];
        hit_b = 1'b1;
      end
    end
  end

  assign ldhz = hz.id_valid && hz.ex_ld && hz.ex_we && (hz.ex_rd != '0) &&
                ((hz.id_rs1_use && (hz.ex_rd == rs1)) ||
                 (hz.id_rs2_use && (hz.ex_rd == rs2)));

  // Without a bypass network any pending producer of a live source must stall.
  assign raw = (EN_FWD == 0) && hz.id_valid &&
               ((hz.id_rs1_use && (rs1 != '0) && hit_a) ||
                (hz.id_rs2_use && (rs2 != '0) && hit_b));

  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    stall_c = 1'b0;
    flush_c = 1'b0;
    if (rst) begin
      if (hz.br_taken) begin
        flush_c = 1'b1;
        if (FLUSH_CYC > 1) begin
          state_n = FLUSH;
          ctr_n   = FL_INIT;
        end else begin
          state_n = RUN;
        end
      end else begin
        unique case (state)
          RUN: begin
            if (ldhz) begin
              stall_c = 1'b1;
              if (LOAD_LAT > 1) begin
                state_n = LDSTALL;
                ctr_n   = LD_INIT;
              end
            end else if (raw) begin
              stall_c = 1'b1;
            end
          end
          LDSTALL: begin
            stall_c = 1'b1;
            if (ctr == '0) state_n = RUN;
            else           ctr_n   = ctr - CTR_W'(1);
          end
          FLUSH: begin
            flush_c = 1'b1;
            if (ctr == '0) state_n = RUN;
            else           ctr_n   = ctr - CTR_W'(1);
          end
          default: state_n = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      ctr         <= '0;
      stall_cnt_q <= '0;
    end else begin
      state <= state_n;
      ctr   <= ctr_n;
      if (stall_c) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign hz.stall       = stall_c;
  assign hz.flush_if_id = flush_c;
  assign hz.stall_cnt   = stall_cnt_q;
  // x0 is hard-wired zero in the register file, so it is never bypassed.
  assign hz.fwd_a = ((EN_FWD != 0) && rst && (rs1 != '0)) ? byp_a : hz.id_a;
  assign hz.fwd_b = ((EN_FWD != 0) && rst && (rs2 != '0)) ? byp_b : hz.id_b;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: a bypassing instance (LOAD_LAT=3, FLUSH_CYC=2) and a
// non-bypassing instance (LOAD_LAT=2, FLUSH_CYC=1) share stimulus against a cycle model.
module tb_hazard_fwd_unit;

  localparam int NF = 3;
  localparam int LL [2] = '{3, 2};
  localparam int FC [2] = '{2, 1};
  localparam int EF [2] = '{1, 0};

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_use, id_rs2_use, ex_we, ex_ld, br_taken;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic [31:0] id_a, id_b;
  logic [4:0]  stg_rd_a [NF];
  logic [31:0] stg_data_a [NF];
  logic [NF-1:0] stg_we;

  int checks = 0;
  int errors = 0;

  int          rem_st [2];
  int          rem_fl [2];
  logic [31:0] cnt [2];

  always #5 clk1 = ~clk1;

  hazard_fwd_if #(.XLEN(32), .RADDR(5), .NUM_FWD(NF)) if_f ();
  hazard_fwd_if #(.XLEN(32), .RADDR(5), .NUM_FWD(NF)) if_r ();

  assign if_f.id_valid = id_valid;     assign if_r.id_valid = id_valid;
  assign if_f.id_rs1 = id_rs1;         assign if_r.id_rs1 = id_rs1;
  assign if_f.id_rs2 = id_rs2;         assign if_r.id_rs2 = id_rs2;
  assign if_f.id_rs1_use = id_rs1_use; assign if_r.id_rs1_use = id_rs1_use;
  assign if_f.id_rs2_use = id_rs2_use; assign if_r.id_rs2_use = id_rs2_use;
  assign if_f.id_a = id_a;             assign if_r.id_a = id_a;
  assign if_f.id_b = id_b;             assign if_r.id_b = id_b;
  assign if_f.ex_rd = ex_rd;           assign if_r.ex_rd = ex_rd;
  assign if_f.ex_we = ex_we;           assign if_r.ex_we = ex_we;
  assign if_f.ex_ld = ex_ld;           assign if_r.ex_ld = ex_ld;
  assign if_f.stg_rd = {stg_rd_a[2], stg_rd_a[1], stg_rd_a[0]};
  assign if_r.stg_rd = {stg_rd_a[2], stg_rd_a[1], stg_rd_a[0]};
  assign if_f.stg_data = {stg_data_a[2], stg_data_a[1], stg_data_a[0]};
  assign if_r.stg_data = {stg_data_a[2], stg_data_a[1], stg_data_a[0]};
  assign if_f.stg_we = stg_we;         assign if_r.stg_we = stg_we;
  assign if_f.br_taken = br_taken;     assign if_r.br_taken = br_taken;

  hazard_fwd_unit #(.XLEN(32), .RADDR(5), .NUM_FWD(NF), .LOAD_LAT(3), .FLUSH_CYC(2), .EN_FWD(1))
    u_fwd (.clk1(clk1), .rst(rst_n), .hz(if_f));
  hazard_fwd_unit #(.XLEN(32), .RADDR(5), .NUM_FWD(NF), .LOAD_LAT(2), .FLUSH_CYC(1), .EN_FWD(0))
    u_raw (.clk1(clk1), .rst(rst_n), .hz(if_r));

  // ---------------- reference model ----------------
  function automatic logic m_ldhz();
    return id_valid && ex_ld && ex_we && (ex_rd != 0) &&
           ((id_rs1_use && ex_rd == id_rs1) || (id_rs2_use && ex_rd == id_rs2));
  endfunction

  function automatic logic m_pending(input logic [4:0] rs);
    if (rs == 0) return 1'b0;
    if (ex_we && ex_rd == rs) return 1'b1;
    for (int i = 0; i < NF; i++) if (stg_we[i] && stg_rd_a[i] == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fwd(input int k, input logic [4:0] rs, input logic [31:0] rf);
    if (!rst_n || EF[k] == 0 || rs == 0) return rf;
    for (int i = 0; i < NF; i++) if (stg_we[i] && stg_rd_a[i] == rs) return stg_data_a[i];
    return rf;
  endfunction

  function automatic void decide(input int k, output logic st, output logic fl,
                                 output int nrs, output int nrf);
    logic rw;
    st = 1'b0; fl = 1'b0; nrs = rem_st[k]; nrf = rem_fl[k];
    if (!rst_n) begin nrs = 0; nrf = 0; return; end
    rw = (EF[k] == 0) && id_valid &&
         ((id_rs1_use && m_pending(id_rs1)) || (id_rs2_use && m_pending(id_rs2)));
    if (br_taken)            begin fl = 1'b1; nrf = FC[k] - 1; nrs = 0; end
    else if (rem_fl[k] > 0)  begin fl = 1'b1; nrf = rem_fl[k] - 1; end
    else if (rem_st[k] > 0)  begin st = 1'b1; nrs = rem_st[k] - 1; end
    else if (m_ldhz())       begin st = 1'b1; nrs = LL[k] - 1; end
    else if (rw)             st = 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin rem_st[k] = 0; rem_fl[k] = 0; cnt[k] = 0; end
  endtask

  task automatic tick();
    logic st, fl;
    int nrs, nrf;
    for (int k = 0; k < 2; k++) begin
      decide(k, st, fl, nrs, nrf);
      if (!rst_n) cnt[k] = 0;
      else if (st && cnt[k] != 32'hFFFF_FFFF) cnt[k] = cnt[k] + 1;
      rem_st[k] = nrs; rem_fl[k] = nrf;
    end
    @(posedge clk1); #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
    id_a = 32'h0; id_b = 32'h0; ex_rd = 0; ex_we = 0; ex_ld = 0; br_taken = 0;
    stg_we = '0;
    for (int i = 0; i < NF; i++) begin stg_rd_a[i] = 0; stg_data_a[i] = 0; end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0; model_reset();
    #2 rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0; model_reset();
    id_valid = 1; id_rs1 = 4; id_rs1_use = 1; id_rs2 = 4; id_rs2_use = 1;
    id_a = 32'hAAAA_0001; id_b = 32'h5555_0002; ex_rd = 4; ex_we = 1; ex_ld = 1;
    stg_rd_a[0] = 4; stg_we = 3'b001; stg_data_a[0] = 32'hDEAD_0000; br_taken = 1;
    for (int c = 0; c < 2; c++) begin
      #2;
      if (if_f.stall !== 1'b0) begin errors++; $display("FAIL rst_stall_f: got %b want 0", if_f.stall); end checks++;
      if (if_r.stall !== 1'b0) begin errors++; $display("FAIL rst_stall_r: got %b want 0", if_r.stall); end checks++;
      if (if_f.flush_if_id !== 1'b0) begin errors++; $display("FAIL rst_flush_f: got %b want 0", if_f.flush_if_id); end checks++;
      if (if_f.fwd_a !== 32'hAAAA_0001) begin errors++; $display("FAIL rst_fwd_a: got %h want aaaa0001", if_f.fwd_a); end checks++;
      if (if_f.fwd_b !== 32'h5555_0002) begin errors++; $display("FAIL rst_fwd_b: got %h want 55550002", if_f.fwd_b); end checks++;
      if (if_f.stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", if_f.stall_cnt); end checks++;
      tick();
    end
  endtask

  task automatic test_bypass_priority();
    do_reset();
    for (int i = 0; i < NF; i++) stg_rd_a[i] = 5;
    stg_data_a[0] = 32'h11; stg_data_a[1] = 32'h22; stg_data_a[2] = 32'h33;
    id_rs1 = 5; id_rs1_use = 1; id_a = 32'hA0; id_rs2 = 5; id_rs2_use = 1; id_b = 32'hB0;
    stg_we = 3'b111; #2;
    if (if_f.fwd_a !== 32'h11) begin errors++; $display("FAIL byp_all: got %h want 11", if_f.fwd_a); end checks++;
    if (if_r.fwd_a !== 32'hA0) begin errors++; $display("FAIL byp_nofwd: got %h want a0", if_r.fwd_a); end checks++;
    stg_we = 3'b110; #2;
    if (if_f.fwd_a !== 32'h22) begin errors++; $display("FAIL byp_110: got %h want 22", if_f.fwd_a); end checks++;
    stg_we = 3'b100; #2;
    if (if_f.fwd_b !== 32'h33) begin errors++; $display("FAIL byp_100: got %h want 33", if_f.fwd_b); end checks++;
    stg_we = 3'b000; #2;
    if (if_f.fwd_a !== 32'hA0) begin errors++; $display("FAIL byp_none: got %h want a0", if_f.fwd_a); end checks++;
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    id_valid = 1; id_rs1 = 0; id_rs1_use = 1; id_a = 32'h0;
    stg_rd_a[0] = 0; stg_we = 3'b001; stg_data_a[0] = 32'hFEED_FACE; #2;
    if (if_f.fwd_a !== 32'h0) begin errors++; $display("FAIL x0_fwd: got %h want 0", if_f.fwd_a); end checks++;
    if (if_f.stall !== 1'b0) begin errors++; $display("FAIL x0_stall_f: got %b want 0", if_f.stall); end checks++;
    if (if_r.stall !== 1'b0) begin errors++; $display("FAIL x0_stall_r: got %b want 0", if_r.stall); end checks++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1; id_rs1 = 1; id_rs2 = 7; id_rs2_use = 1;
    ex_ld = 1; ex_we = 1; ex_rd = 7;
    for (int c = 0; c < 4; c++) begin
      #2;
      if (if_f.stall !== (c < 3)) begin errors++; $display("FAIL ld_stall_c%0d: got %b want %b", c, if_f.stall, (c < 3)); end checks++;
      if (if_f.flush_if_id !== 1'b0) begin errors++; $display("FAIL ld_flush_c%0d: got %b want 0", c, if_f.flush_if_id); end checks++;
      tick();
      if (c == 0) begin ex_ld = 0; ex_we = 0; end
    end
    if (if_f.stall_cnt !== 32'd3) begin errors++; $display("FAIL ld_cnt_f: got %0d want 3", if_f.stall_cnt); end checks++;
    if (if_r.stall_cnt !== 32'd2) begin errors++; $display("FAIL ld_cnt_r: got %0d want 2", if_r.stall_cnt); end checks++;
  endtask

  task automatic test_branch_in_ldstall();
    do_reset();
    id_valid = 1; id_rs2 = 7; id_rs2_use = 1; ex_ld = 1; ex_we = 1; ex_rd = 7; #2;
    if (if_f.stall !== 1'b1) begin errors++; $display("FAIL br_ld_stall: got %b want 1", if_f.stall); end checks++;
    tick();
    ex_ld = 0; ex_we = 0; br_taken = 1; #2;
    if (if_f.stall !== 1'b0) begin errors++; $display("FAIL br_ovr_stall: got %b want 0", if_f.stall); end checks++;
    if (if_f.flush_if_id !== 1'b1) begin errors++; $display("FAIL br_flush1: got %b want 1", if_f.flush_if_id); end checks++;
    tick();
    br_taken = 0; #2;
    if (if_f.flush_if_id !== 1'b1) begin errors++; $display("FAIL br_flush2: got %b want 1", if_f.flush_if_id); end checks++;
    if (if_f.stall !== 1'b0) begin errors++; $display("FAIL br_flush2_stall: got %b want 0", if_f.stall); end checks++;
    if (if_r.flush_if_id !== 1'b0) begin errors++; $display("FAIL br_flush_r: got %b want 0", if_r.flush_if_id); end checks++;
    tick();
    #2;
    if (if_f.flush_if_id !== 1'b0) begin errors++; $display("FAIL br_flush_end: got %b want 0", if_f.flush_if_id); end checks++;
    if (if_f.stall_cnt !== 32'd1) begin errors++; $display("FAIL br_cnt: got %0d want 1", if_f.stall_cnt); end checks++;
    tick();
  endtask

  task automatic test_raw_nofwd();
    do_reset();
    id_valid = 1; id_rs1 = 9; id_rs1_use = 1; id_a = 32'h0000_1234;
    stg_rd_a[2] = 9; stg_we = 3'b100; stg_data_a[2] = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      #2;
      if (if_r.stall !== 1'b1) begin errors++; $display("FAIL raw_stall_c%0d: got %b want 1", c, if_r.stall); end checks++;
      if (if_r.fwd_a !== 32'h0000_1234) begin errors++; $display("FAIL raw_fwd_c%0d: got %h want 00001234", c, if_r.fwd_a); end checks++;
      if (if_f.stall !== 1'b0) begin errors++; $display("FAIL raw_f_stall_c%0d: got %b want 0", c, if_f.stall); end checks++;
      if (if_f.fwd_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_f_fwd_c%0d: got %h want deadbeef", c, if_f.fwd_a); end checks++;
      tick();
    end
    stg_we = 3'b000; #2;
    if (if_r.stall !== 1'b0) begin errors++; $display("FAIL raw_clear: got %b want 0", if_r.stall); end checks++;
    if (if_r.stall_cnt !== 32'd3) begin errors++; $display("FAIL raw_cnt: got %0d want 3", if_r.stall_cnt); end checks++;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    id_valid = 1; id_rs1 = 3; id_rs1_use = 1; ex_ld = 1; ex_we = 1; ex_rd = 3;
    tick();
    ex_ld = 0; ex_we = 0; br_taken = 1;
    tick();
    br_taken = 0; #2;
    if (if_f.flush_if_id !== 1'b1) begin errors++; $display("FAIL ar_in_flush: got %b want 1", if_f.flush_if_id); end checks++;
    if (if_f.stall_cnt !== 32'd1) begin errors++; $display("FAIL ar_cnt_pre: got %0d want 1", if_f.stall_cnt); end checks++;
    #1 rst_n = 1'b0; model_reset();
    #1;
    if (if_f.flush_if_id !== 1'b0) begin errors++; $display("FAIL ar_flush_drop: got %b want 0", if_f.flush_if_id); end checks++;
    if (if_f.stall_cnt !== 32'd0) begin errors++; $display("FAIL ar_cnt_clr: got %0d want 0", if_f.stall_cnt); end checks++;
    rst_n = 1'b1; #1;
    if (if_f.flush_if_id !== 1'b0) begin errors++; $display("FAIL ar_run: got %b want 0", if_f.flush_if_id); end checks++;
    tick();
    #2;
    if (if_f.flush_if_id !== 1'b0 || if_f.stall !== 1'b0) begin
      errors++; $display("FAIL ar_after: got flush %b stall %b want 0 0", if_f.flush_if_id, if_f.stall);
    end checks++;
    if (if_f.stall_cnt !== 32'd0) begin errors++; $display("FAIL ar_cnt_post: got %0d want 0", if_f.stall_cnt); end checks++;
    tick();
  endtask

  task automatic test_random();
    logic est, efl, ost, ofl;
    int nrs, nrf;
    logic [31:0] ea, eb, oa, ob, oc;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      id_valid = ($urandom_range(0, 9) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rs1_use = 1'($urandom); id_rs2_use = 1'($urandom);
      id_a = $urandom; id_b = $urandom;
      ex_rd = 5'($urandom_range(0, 3)); ex_we = 1'($urandom);
      ex_ld = ($urandom_range(0, 2) == 0);
      stg_we = 3'($urandom);
      for (int i = 0; i < NF; i++) begin stg_rd_a[i] = 5'($urandom_range(0, 3)); stg_data_a[i] = $urandom; end
      br_taken = ($urandom_range(0, 11) == 0);
      #2;
      for (int k = 0; k < 2; k++) begin
        decide(k, est, efl, nrs, nrf);
        ea = m_fwd(k, id_rs1, id_a); eb = m_fwd(k, id_rs2, id_b);
        if (k == 0) begin ost = if_f.stall; ofl = if_f.flush_if_id; oa = if_f.fwd_a; ob = if_f.fwd_b; oc = if_f.stall_cnt; end
        else        begin ost = if_r.stall; ofl = if_r.flush_if_id; oa = if_r.fwd_a; ob = if_r.fwd_b; oc = if_r.stall_cnt; end
        if (ost !== est) begin errors++; $display("FAIL rnd_stall[%0d] n=%0d: got %b want %b", k, n, ost, est); end checks++;
        if (ofl !== efl) begin errors++; $display("FAIL rnd_flush[%0d] n=%0d: got %b want %b", k, n, ofl, efl); end checks++;
        if (oa !== ea) begin errors++; $display("FAIL rnd_fwd_a[%0d] n=%0d: got %h want %h", k, n, oa, ea); end checks++;
        if (ob !== eb) begin errors++; $display("FAIL rnd_fwd_b[%0d] n=%0d: got %h want %h", k, n, ob, eb); end checks++;
        if (oc !== cnt[k]) begin errors++; $display("FAIL rnd_cnt[%0d] n=%0d: got %0d want %0d", k, n, oc, cnt[k]); end checks++;
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_bypass_priority();
    test_x0();
    test_load_use();
    test_branch_in_ldstall();
    test_raw_nofwd();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
